// File: rtl/fpu_types_pkg.sv
// Shared types for the half-precision FPU sequencer: instruction fields,
// datapath operations and sequencer state encoding.
package fpu_types_pkg;

  typedef enum logic [3:0] {
    FPU_HALF_ADD,
    FPU_HALF_SUB,
    FPU_HALF_MUL,
    FPU_HALF_DIV,
    FPU_HALF_SQRT,
    FPU_HALF_MADD,
    FPU_HALF_MSUB,
    FPU_HALF_NMADD,
    FPU_HALF_NMSUB,
    FPU_HALF_SGNJ,
    FPU_HALF_MIN,
    FPU_HALF_MAX,
    FPU_HALF_CMP,
    FPU_HALF_CLASS
  } fpu_operation_t;

  typedef enum logic [6:0] {
    OPC_OPFP   = 7'b1010011,
    OPC_FMADD  = 7'b1000011,
    OPC_FMSUB  = 7'b1000111,
    OPC_FNMSUB = 7'b1001011,
    OPC_FNMADD = 7'b1001111
  } fpu_opcode_t;

  typedef enum logic [4:0] {
    FUNCT_ADD    = 5'h00,
    FUNCT_SUB    = 5'h01,
    FUNCT_MUL    = 5'h02,
    FUNCT_DIV    = 5'h03,
    FUNCT_SGNJ   = 5'h04,
    FUNCT_MINMAX = 5'h05,
    FUNCT_SQRT   = 5'h0B,
    FUNCT_COMP   = 5'h14,
    FUNCT_CLASS  = 5'h1C
  } fpu_funct_t;

  typedef enum logic [1:0] {
    FMT_SINGLE = 2'b00,
    FMT_DOUBLE = 2'b01,
    FMT_HALF   = 2'b10,
    FMT_QUAD   = 2'b11
  } fpu_fmt_t;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100,
    RM_DYN = 3'b111
  } fpu_rm_t;

  // Plain encoded constants keep the state register compatible with older tooling.
  typedef logic [1:0] fpu_seq_state_t;
  localparam fpu_seq_state_t SEQ_IDLE  = 2'd0;
  localparam fpu_seq_state_t SEQ_ISSUE = 2'd1;
  localparam fpu_seq_state_t SEQ_WAIT  = 2'd2;
  localparam fpu_seq_state_t SEQ_RESP  = 2'd3;

endpackage

// File: rtl/fpu_half_decode.sv
// Combinational Zhinx decoder: maps an instruction word to a datapath
// operation, the rounding mode to hand the unit, and an illegal flag.
module fpu_half_decode
  import fpu_types_pkg::*;
(
  input  logic [31:0]    instr,
  input  logic [2:0]     frm,
  output fpu_operation_t op,
  output logic [2:0]     rm_eff,
  output logic           illegal
);

  fpu_opcode_t opcode;
  fpu_funct_t  funct5;
  fpu_fmt_t    fmt;
  logic [2:0]  rm;
  logic [4:0]  rs2;
  logic        rounding;
  logic        unused_fields;

  assign opcode        = fpu_opcode_t'(instr[6:0]);
  assign rm            = instr[14:12];
  assign rs2           = instr[24:20];
  assign fmt           = fpu_fmt_t'(instr[26:25]);
  assign funct5        = fpu_funct_t'(instr[31:27]);
  assign unused_fields = ^{instr[11:7], instr[19:15]};

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    op       = FPU_HALF_ADD;
    rounding = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OPC_OPFP: begin
        case (funct5)
          FUNCT_ADD:  begin op = FPU_HALF_ADD; rounding = 1'b1; end
          FUNCT_SUB:  begin op = FPU_HALF_SUB; rounding = 1'b1; end
          FUNCT_MUL:  begin op = FPU_HALF_MUL; rounding = 1'b1; end
          FUNCT_DIV:  begin op = FPU_HALF_DIV; rounding = 1'b1; end
          FUNCT_SQRT: begin
            op       = FPU_HALF_SQRT;
            rounding = 1'b1;
            illegal  = (rs2 != 5'd0);
          end
          FUNCT_SGNJ: begin
            op      = FPU_HALF_SGNJ;
            illegal = (rm > RM_RDN);
          end
          FUNCT_MINMAX: begin
            if (rm == 3'b000)      op = FPU_HALF_MIN;
            else if (rm == 3'b001) op = FPU_HALF_MAX;
            else                   illegal = 1'b1;
          end
          FUNCT_COMP: begin
            op      = FPU_HALF_CMP;
            illegal = (rm > RM_RDN);
          end
          FUNCT_CLASS: begin
            op      = FPU_HALF_CLASS;
            illegal = (rm != 3'b001) || (rs2 != 5'd0);
          end
          default: illegal = 1'b1;
        endcase
      end
      OPC_FMADD:  begin op = FPU_HALF_MADD;  rounding = 1'b1; end
      OPC_FMSUB:  begin op = FPU_HALF_MSUB;  rounding = 1'b1; end
      OPC_FNMADD: begin op = FPU_HALF_NMADD; rounding = 1'b1; end
      OPC_FNMSUB: begin op = FPU_HALF_NMSUB; rounding = 1'b1; end
      default:    illegal = 1'b1;
    endcase

    // Non-rounding ops pass the raw rm through as a sub-select.
    rm_eff = rm;
    if (rounding) begin
      rm_eff = (rm == RM_DYN) ? frm : rm;
      if (rm_eff > RM_RMM) illegal = 1'b1;
    end

    if (fmt != FMT_HALF) illegal = 1'b1;
  end

endmodule

// File: rtl/fpu_half_seq.sv
// Single-outstanding sequencer: accepts one Zhinx instruction, issues it to
// the FPU datapath, waits (bounded) for completion and holds the response.
module fpu_half_seq
  import fpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT = 32
) (
  input  logic           CLK,
  input  logic           nRST,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [31:0]    instr,
  input  logic [2:0]     frm,
  output logic           unit_start,
  output fpu_operation_t unit_op,
  output logic [2:0]     unit_rm,
  input  logic           unit_done,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic           resp_illegal,
  output logic           resp_timeout,
  output logic           busy
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  fpu_seq_state_t state;
  logic [7:0]     cnt;
  fpu_operation_t dec_op;
  logic [2:0]     dec_rm;
  logic           dec_illegal;

  fpu_half_decode u_decode (
    .instr   (instr),
    .frm     (frm),
    .op      (dec_op),
    .rm_eff  (dec_rm),
    .illegal (dec_illegal)
  );

  // Gated by nRST so the sequencer never advertises readiness while held in reset.
  assign req_ready  = nRST && (state == SEQ_IDLE);
  assign unit_start = (state == SEQ_ISSUE);
  assign resp_valid = (state == SEQ_RESP);
  assign busy       = (state != SEQ_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= SEQ_IDLE;
      cnt          <= 8'd0;
      unit_op      <= FPU_HALF_ADD;
      unit_rm      <= 3'b000;
      resp_illegal <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      case (state)
        SEQ_IDLE: begin
          cnt <= 8'd0;
          if (req_valid) begin
            unit_op      <= dec_op;
            unit_rm      <= dec_rm;
            resp_illegal <= dec_illegal;
            resp_timeout <= 1'b0;
            state        <= dec_illegal ? SEQ_RESP : SEQ_ISSUE;
          end
        end
        SEQ_ISSUE: begin
          // Counting starts at issue so the timeout lands TIMEOUT cycles after unit_start.
          cnt   <= cnt + 8'd1;
          state <= unit_done ? SEQ_RESP : SEQ_WAIT;
        end
        SEQ_WAIT: begin
          cnt <= cnt + 8'd1;
          if (unit_done) begin
            state <= SEQ_RESP;
          end else if (cnt == CNT_LAST) begin
            state        <= SEQ_RESP;
            resp_timeout <= 1'b1;
          end
        end
        SEQ_RESP: begin
          if (resp_ready) begin
            state        <= SEQ_IDLE;
            resp_illegal <= 1'b0;
            resp_timeout <= 1'b0;
          end
        end
        default: state <= SEQ_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fpu_half_seq.md
FPU_HALF_SEQ -- requirements
Module: fpu_half_seq

Interface
REQ-001 Parameter: TIMEOUT, default 32, max cycles to wait for unit_done after issue (legal range 2..255).
REQ-002 Port: CLK  input  1  clock; all state updates on rising edge.
REQ-003 Port: nRST  input  1  reset; asynchronous and active-low.
REQ-004 Port: req_valid  input  1  instruction offered.
REQ-005 Port: req_ready  output  1  sequencer accepts an instruction.
REQ-006 Port: instr  input  32  Zhinx R-/R4-type instruction word.
REQ-007 Port: frm  input  3  dynamic rounding mode from the fcsr.
REQ-008 Port: unit_start  output  1  one-cycle issue pulse to the FPU datapath.
REQ-009 Port: unit_op  output  fpu_operation_t  operation to execute.
REQ-010 Port: unit_rm  output  3  effective rounding mode or sub-select.
REQ-011 Port: unit_done  input  1  datapath result ready.
REQ-012 Port: resp_valid  output  1  completion or error response pending.
REQ-013 Port: resp_ready  input  1  consumer takes response.
REQ-014 Port: resp_illegal  output  1  response is an illegal-instruction trap.
REQ-015 Port: resp_timeout  output  1  response is a unit timeout.
REQ-016 Port: busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; req_ready=1 only in IDLE.
REQ-018 IDLE with req_valid: decode is registered; if illegal go to RESP with resp_illegal=1, otherwise go to ISSUE.
REQ-019 ISSUE: unit_start=1 for exactly one cycle; if unit_done is high the same cycle go to RESP, otherwise go to WAIT.
REQ-020 WAIT: the cycle counter increments each cycle; unit_done leads to RESP.
REQ-021 WAIT: when the counter reaches TIMEOUT-1 without unit_done, go to RESP with resp_timeout=1.
REQ-022 unit_done SHALL be ignored in IDLE and RESP.
REQ-023 RESP: resp_valid is held with stable flags until resp_ready, then the FSM returns to IDLE; req_ready stays 0 in that cycle (no back-to-back accept).
REQ-024 unit_op and unit_rm SHALL stay stable from ISSUE until leaving RESP.
REQ-025 Latency, accept at cycle N: unit_start at N+1, earliest resp_valid at N+2; illegal instruction gives resp_valid at N+1.
REQ-026 Decode fields: opcode=instr[6:0], rm=instr[14:12], rs2=instr[24:20], fmt=instr[26:25], funct5=instr[31:27].
REQ-027 Illegal if the opcode is not one of OPFP/FMADD/FMSUB/FNMADD/FNMSUB.
REQ-028 Illegal if fmt != FMT_HALF.
REQ-029 Rounding ops are ADD, SUB, MUL, DIV, SQRT and the four fused ops.
REQ-030 For rounding ops, effective rm = frm when rm==RM_DYN, else rm; effective rm in {101,110,111} is illegal.
REQ-031 FMINMAX: rm 000 maps to MIN, 001 to MAX, any other rm is illegal.
REQ-032 FSGNJ and FCOMP: rm above 010 is illegal.
REQ-033 FCLASS: rm must be 001 and rs2 must be 0; FSQRT: rs2 must be 0; an unknown funct5 is illegal.
REQ-034 unit_rm SHALL carry the effective rm for rounding ops and raw rm otherwise.
REQ-035 Fused opcodes map to MADD/MSUB/NMADD/NMSUB with funct5 ignored, except fmt.

Reset
REQ-036 nRST low SHALL force IDLE asynchronously, counter=0, unit_op=FPU_HALF_ADD, unit_rm=000.
REQ-037 nRST low SHALL force all 1-bit outputs to 0 except req_ready, which is 0 while nRST is low and 1 after release.
REQ-038 Reset mid-operation SHALL drop any pending response; the first accept is on the first CLK edge after release.

Structure
REQ-039 fpu_operation_t, fpu_opcode_t, fpu_funct_t, fpu_fmt_t, fpu_rm_t and a new fpu_seq_state_t SHALL live in fpu_types_pkg.
REQ-040 Decode SHALL be a combinational sub-module fpu_half_decode with inputs instr and frm and outputs op, rm_eff and illegal; the FSM and counter live in fpu_half_seq.

Verification
REQ-041 Scenario: instr=0x042081D3 (FADD.H, rm=000), unit_done high 3 cycles after unit_start -> unit_op=ADD, unit_rm=000, resp_valid with no flags.
REQ-042 Scenario: instr=0x002081D3 (fmt=single) -> resp_valid at N+1, resp_illegal=1, unit_start never asserted.
REQ-043 Scenario: instr=0x1C20F1D3 (FDIV.H, rm=DYN) with frm=101 -> illegal; repeat with frm=010 -> unit_op=DIV, unit_rm=010.
REQ-044 Scenario: legal op, unit_done never asserted, TIMEOUT=32 -> resp_timeout=1 exactly TIMEOUT cycles after unit_start.
REQ-045 Scenario: unit_done in the ISSUE cycle with resp_ready held low 5 cycles -> resp_valid held 5+ cycles, stable, then IDLE.
REQ-046 Scenario: nRST pulsed low during WAIT -> outputs reset immediately and no resp_valid after release.
